// File: rtl/ucsbece154b_perfmon_if.sv
// Read port of the performance monitor.
//   rd_req_i  : single-cycle read request
//   rd_sel_i  : counter select (0..5 counters, 6 status, 7 zero)
//   rd_ack_o  : one-cycle pulse, data valid, in the cycle after the request
//   rd_data_o : registered read data; holds its value between reads
// The monitor connects through the slave modport. A requester (debug bridge,
// bench) connects through the master modport.
interface ucsbece154b_perfmon_if #(
    parameter int WIDTH = 32
);
    logic             rd_req_i;
    logic [2:0]       rd_sel_i;
    logic             rd_ack_o;
    logic [WIDTH-1:0] rd_data_o;

    modport master (
        output rd_req_i,
        output rd_sel_i,
        input  rd_ack_o,
        input  rd_data_o
    );

    modport slave (
        input  rd_req_i,
        input  rd_sel_i,
        output rd_ack_o,
        output rd_data_o
    );
endinterface

// File: rtl/ucsbece154b_perfmon.sv
// Performance monitor for the dual-issue pipeline.
// It samples execute-stage events from both issue slots, plus the fetch PC. It
// keeps saturating counters for cycles, instructions, branches, branch misses,
// jumps and jump misses. It also detects program completion, which is a
// self-loop at HALT_PC.
// Ports:
//   clk           : core clock, rising edge
//   reset         : synchronous, active-low reset
//   enable_i      : counting gate
//   pcf_i         : fetch PC, slot 1
//   pce1_i/pce2_i : execute PCs, slot 1 and slot 2
//   ope1_i        : execute opcode, slot 1
//   mispredict_i  : slot-1 branch mispredict
//   taken_i       : slot-1 branch/jump taken
//   clear_i       : synchronous clear of the counters and the state
//   rd            : registered request/acknowledge read port (slave side)
//   halted_o      : high while the state is HALTED
//   overflow_o    : sticky, set when any counter saturates
module ucsbece154b_perfmon #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] HALT_PC  = 32'h0001005c,
    parameter logic [31:0] PC_LIMIT = 32'h00010060
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic [31:0] pcf_i,
    input  logic [31:0] pce1_i,
    input  logic [31:0] pce2_i,
    input  logic [6:0]  ope1_i,
    input  logic        mispredict_i,
    input  logic        taken_i,
    input  logic        clear_i,
    ucsbece154b_perfmon_if.slave rd,
    output logic        halted_o,
    output logic        overflow_o
);

    localparam int         NUM_CNT   = 6;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      prev_pcf_reg;
    logic             overflow_reg, overflow_next;
    logic             count_en;
    logic             halt_detect;
    logic             rd_ack_reg;
    logic [WIDTH-1:0] rd_data_reg, rd_data_next;
    logic [WIDTH-1:0] status;

    logic             is_branch, is_jump, slot1_valid, slot2_valid;
    logic [1:0]       inc [NUM_CNT];
    logic [WIDTH-1:0] cnt_val [NUM_CNT];
    logic [NUM_CNT-1:0] sat;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign is_branch   = (ope1_i == OP_BRANCH);
    assign is_jump     = (ope1_i == OP_JAL) || (ope1_i == OP_JALR);
    assign slot1_valid = (pce1_i != 32'd0);
    // Slot-2 PCs past the end of the program are speculative fetch debris.
    assign slot2_valid = (pce2_i != 32'd0) && (pce2_i < PC_LIMIT);

    always_comb begin
        inc[0] = 2'd1;
        inc[1] = {1'b0, slot1_valid} + {1'b0, slot2_valid};
        inc[2] = {1'b0, is_branch};
        inc[3] = {1'b0, is_branch & mispredict_i};
        inc[4] = {1'b0, is_jump};
        inc[5] = {1'b0, is_jump & ~taken_i};
    end

    // Completion: the final instruction is in execute and fetch is spinning
    // on the same PC, which is the program's terminal self-loop.
    assign halt_detect = (pce1_i == HALT_PC) && (pcf_i == prev_pcf_reg);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_en   = 1'b0;
        if (clear_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    // The cycle that starts the run is counted.
                    if (enable_i) begin
                        count_en   = 1'b1;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    count_en = enable_i;
                    if (halt_detect) begin
                        state_next = HALTED;
                    end
                end
                HALTED:  state_next = HALTED;
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating counters
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : gen_cnt
            logic [WIDTH-1:0] cnt_reg;
            logic [WIDTH:0]   sum;

            // One extra bit catches any step past all-ones, including +2
            // from all-ones minus one.
            assign sum         = {1'b0, cnt_reg} + {{(WIDTH-1){1'b0}}, inc[gi]};
            assign sat[gi]     = sum[WIDTH];
            assign cnt_val[gi] = cnt_reg;

            always_ff @(posedge clk) begin
                if (!reset || clear_i) begin
                    cnt_reg <= '0;
                end else if (count_en) begin
                    cnt_reg <= sat[gi] ? '1 : sum[WIDTH-1:0];
                end
            end
        end
    endgenerate

    assign overflow_next = clear_i ? 1'b0 : (overflow_reg | (count_en & (|sat)));

    // ------------------------------------------------------------------
    // Read port: data is taken before this edge's update, so a read that
    // coincides with clear_i returns the value before the clear.
    // ------------------------------------------------------------------
    always_comb begin
        status       = '0;
        status[3:0]  = {overflow_reg, halted_o, state_reg};
        rd_data_next = '0;
        case (rd.rd_sel_i)
            3'd0:    rd_data_next = cnt_val[0];
            3'd1:    rd_data_next = cnt_val[1];
            3'd2:    rd_data_next = cnt_val[2];
            3'd3:    rd_data_next = cnt_val[3];
            3'd4:    rd_data_next = cnt_val[4];
            3'd5:    rd_data_next = cnt_val[5];
            3'd6:    rd_data_next = status;
            default: rd_data_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_pcf_reg <= '0;
            overflow_reg <= 1'b0;
            rd_ack_reg   <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            prev_pcf_reg <= clear_i ? 32'd0 : pcf_i;
            overflow_reg <= overflow_next;
            rd_ack_reg   <= rd.rd_req_i;
            if (rd.rd_req_i) begin
                rd_data_reg <= rd_data_next;
            end
        end
    end

    assign rd.rd_ack_o  = rd_ack_reg;
    assign rd.rd_data_o = rd_data_reg;
    assign halted_o     = (state_reg == HALTED);
    assign overflow_o   = overflow_reg;

endmodule

// File: tb/tb_ucsbece154b_perfmon.sv
// Bench for ucsbece154b_perfmon. It runs two instances side by side. Instance A
// uses WIDTH=32. Instance B uses WIDTH=4, so that saturation is reached quickly.
// A behavioural reference model checks both instances every cycle. A table of
// directed phases, and hand-written sequences, compare the counters against
// fixed values.
module tb_ucsbece154b_perfmon;

    localparam logic [31:0] HALT_PC  = 32'h0001005c;
    localparam logic [31:0] PC_LIMIT = 32'h00010060;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_i;
    logic [31:0] pcf_i, pce1_i, pce2_i;
    logic [6:0]  ope1_i;
    logic        mispredict_i, taken_i, clear_i;
    logic        req;
    logic [2:0]  sel;
    logic        halted_a, ovf_a, halted_b, ovf_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ucsbece154b_perfmon_if #(.WIDTH(32)) rd_a ();
    ucsbece154b_perfmon_if #(.WIDTH(4))  rd_b ();

    assign rd_a.rd_req_i = req;
    assign rd_a.rd_sel_i = sel;
    assign rd_b.rd_req_i = req;
    assign rd_b.rd_sel_i = sel;

    ucsbece154b_perfmon #(.WIDTH(32), .HALT_PC(HALT_PC), .PC_LIMIT(PC_LIMIT)) dut_a (
        .clk(clk), .reset(reset), .enable_i(enable_i), .pcf_i(pcf_i),
        .pce1_i(pce1_i), .pce2_i(pce2_i), .ope1_i(ope1_i),
        .mispredict_i(mispredict_i), .taken_i(taken_i), .clear_i(clear_i),
        .rd(rd_a.slave), .halted_o(halted_a), .overflow_o(ovf_a)
    );

    ucsbece154b_perfmon #(.WIDTH(4), .HALT_PC(HALT_PC), .PC_LIMIT(PC_LIMIT)) dut_b (
        .clk(clk), .reset(reset), .enable_i(enable_i), .pcf_i(pcf_i),
        .pce1_i(pce1_i), .pce2_i(pce2_i), .ope1_i(ope1_i),
        .mispredict_i(mispredict_i), .taken_i(taken_i), .clear_i(clear_i),
        .rd(rd_b.slave), .halted_o(halted_b), .overflow_o(ovf_b)
    );

    // ------------------------------------------------------------------
    // Reference model: state 0 idle, 1 running, 2 halted
    // ------------------------------------------------------------------
    longint unsigned m_cnt [2][6];
    longint unsigned m_data [2];
    longint unsigned m_max [2] = '{64'hFFFF_FFFF, 64'd15};
    bit              m_ovf [2];
    bit              m_ack;
    int              m_state;
    logic [31:0]     m_prev;

    function automatic longint unsigned m_read(input int k, input logic [2:0] s);
        if (s < 3'd6) return m_cnt[k][s];
        if (s == 3'd6) return (longint'(m_ovf[k]) << 3) | (longint'(m_state == 2) << 2)
                              | longint'(m_state);
        return 0;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) m_cnt[k][i] = 0;
            m_ovf[k] = 1'b0;
        end
        m_state = 0;
        m_prev  = 32'd0;
    endtask

    task automatic m_update();
        longint unsigned inc [6];
        longint unsigned s;
        bit counted;
        int nxt;
        if (!reset) begin
            m_clear();
            m_ack     = 1'b0;
            m_data[0] = 0;
            m_data[1] = 0;
        end else begin
            m_ack = req;
            if (req) begin
                m_data[0] = m_read(0, sel);
                m_data[1] = m_read(1, sel);
            end
            if (clear_i) begin
                m_clear();
            end else begin
                counted = enable_i && (m_state != 2);
                nxt = m_state;
                if (m_state == 0 && enable_i) nxt = 1;
                else if (m_state == 1 && pce1_i == HALT_PC && pcf_i == m_prev) nxt = 2;
                inc[0] = 1;
                inc[1] = ((pce1_i != 0) ? 1 : 0) + ((pce2_i != 0 && pce2_i < PC_LIMIT) ? 1 : 0);
                inc[2] = (ope1_i == 7'h63) ? 1 : 0;
                inc[3] = (ope1_i == 7'h63 && mispredict_i) ? 1 : 0;
                inc[4] = (ope1_i == 7'h6f || ope1_i == 7'h67) ? 1 : 0;
                inc[5] = ((ope1_i == 7'h6f || ope1_i == 7'h67) && !taken_i) ? 1 : 0;
                if (counted) begin
                    for (int k = 0; k < 2; k++) begin
                        for (int i = 0; i < 6; i++) begin
                            s = m_cnt[k][i] + inc[i];
                            if (s > m_max[k]) begin
                                m_cnt[k][i] = m_max[k];
                                m_ovf[k]    = 1'b1;
                            end else begin
                                m_cnt[k][i] = s;
                            end
                        end
                    end
                end
                m_state = nxt;
                m_prev  = pcf_i;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: DUT and model both sample at the rising edge, outputs are
    // compared at the falling edge.
    task automatic step();
        @(posedge clk);
        m_update();
        @(negedge clk);
        chk("ack_a",    {63'd0, rd_a.rd_ack_o}, {63'd0, m_ack});
        chk("data_a",   {32'd0, rd_a.rd_data_o}, m_data[0]);
        chk("halted_a", {63'd0, halted_a}, {63'd0, m_state == 2});
        chk("ovf_a",    {63'd0, ovf_a}, {63'd0, m_ovf[0]});
        chk("ack_b",    {63'd0, rd_b.rd_ack_o}, {63'd0, m_ack});
        chk("data_b",   {60'd0, rd_b.rd_data_o}, m_data[1]);
        chk("halted_b", {63'd0, halted_b}, {63'd0, m_state == 2});
        chk("ovf_b",    {63'd0, ovf_b}, {63'd0, m_ovf[1]});
    endtask

    function automatic logic [63:0] sat4(input logic [63:0] v);
        return (v > 64'd15) ? 64'd15 : v;
    endfunction

    // Single read, compared against fixed expectations for both widths.
    task automatic rd_check(input logic [2:0] s, input logic [63:0] exp_a,
                            input logic [63:0] exp_b, input string nm);
        req = 1'b1;
        sel = s;
        step();
        req = 1'b0;
        chk({nm, "_a"}, {32'd0, rd_a.rd_data_o}, exp_a);
        chk({nm, "_b"}, {60'd0, rd_b.rd_data_o}, exp_b);
        $display("read sel=%0d a=%0h b=%0h", s, rd_a.rd_data_o, rd_b.rd_data_o);
    endtask

    typedef struct {
        logic        en;
        logic [31:0] pce1;
        logic [31:0] pce2;
        logic [6:0]  ope;
        logic        misp;
        logic        taken;
        int          n;
        logic [63:0] e_cyc, e_ins, e_br, e_brm, e_j, e_jm;
    } phase_t;

    phase_t tbl [9];

    initial begin
        // Cumulative counter expectations after each phase (instance A).
        tbl[0] = '{1'b1, 32'h10000, 32'h10004, 7'h33, 1'b0, 1'b0, 10, 10, 20, 0, 0, 0, 0};
        tbl[1] = '{1'b1, 32'h10000, 32'h10060, 7'h33, 1'b0, 1'b0, 3,  13, 23, 0, 0, 0, 0};
        tbl[2] = '{1'b1, 32'h0,     32'h0,     7'h33, 1'b0, 1'b0, 2,  15, 23, 0, 0, 0, 0};
        tbl[3] = '{1'b1, 32'h10000, 32'h0,     7'h63, 1'b1, 1'b0, 1,  16, 24, 1, 1, 0, 0};
        tbl[4] = '{1'b1, 32'h10000, 32'h0,     7'h63, 1'b0, 1'b0, 3,  19, 27, 4, 1, 0, 0};
        tbl[5] = '{1'b1, 32'h10000, 32'h0,     7'h6f, 1'b0, 1'b1, 1,  20, 28, 4, 1, 1, 0};
        tbl[6] = '{1'b1, 32'h10000, 32'h0,     7'h6f, 1'b0, 1'b0, 1,  21, 29, 4, 1, 2, 1};
        tbl[7] = '{1'b0, 32'h10000, 32'h0,     7'h63, 1'b1, 1'b0, 3,  21, 29, 4, 1, 2, 1};
        tbl[8] = '{1'b1, 32'h10000, 32'h1005c, 7'h67, 1'b0, 1'b0, 1,  22, 31, 4, 1, 3, 2};

        reset = 1'b0; enable_i = 1'b0; pcf_i = 32'h10000; pce1_i = 0; pce2_i = 0;
        ope1_i = 7'h33; mispredict_i = 1'b0; taken_i = 1'b0; clear_i = 1'b0;
        req = 1'b0; sel = 3'd0;

        // Reset, then read every select: all zero, status idle.
        step();
        step();
        reset = 1'b1;
        for (int s = 0; s < 7; s++) rd_check(3'(s), 0, 0, "rst_read");

        // Directed phases, each followed by a read-back of all six counters.
        for (int p = 0; p < 9; p++) begin
            enable_i = tbl[p].en; pce1_i = tbl[p].pce1; pce2_i = tbl[p].pce2;
            ope1_i = tbl[p].ope; mispredict_i = tbl[p].misp; taken_i = tbl[p].taken;
            for (int c = 0; c < tbl[p].n; c++) step();
            enable_i = 1'b0;
            rd_check(3'd0, tbl[p].e_cyc, sat4(tbl[p].e_cyc), "cycles");
            rd_check(3'd1, tbl[p].e_ins, sat4(tbl[p].e_ins), "instr");
            rd_check(3'd2, tbl[p].e_br,  sat4(tbl[p].e_br),  "branch");
            rd_check(3'd3, tbl[p].e_brm, sat4(tbl[p].e_brm), "br_miss");
            rd_check(3'd4, tbl[p].e_j,   sat4(tbl[p].e_j),   "jump");
            rd_check(3'd5, tbl[p].e_jm,  sat4(tbl[p].e_jm),  "j_miss");
        end

        // Halt: fetch spins on 0x10060 while the final PC reaches execute.
        enable_i = 1'b1; pce2_i = 0; ope1_i = 7'h33; pcf_i = 32'h10060; pce1_i = 32'h10058;
        step();
        chk("not_halted_yet", {63'd0, halted_a}, 64'd0);
        pce1_i = HALT_PC;
        step();
        chk("halt_rise", {63'd0, halted_a}, 64'd1);
        for (int c = 0; c < 3; c++) step();
        enable_i = 1'b0;
        rd_check(3'd0, 24, 15, "cyc_frozen");
        rd_check(3'd1, 33, 15, "ins_frozen");
        rd_check(3'd6, 6, 4'b1110, "status_halt");

        // Clear with a coincident read: the read returns the pre-clear value.
        clear_i = 1'b1; req = 1'b1; sel = 3'd0;
        step();
        clear_i = 1'b0; req = 1'b0; pce1_i = 0; pcf_i = 32'h10000;
        chk("clr_read", {32'd0, rd_a.rd_data_o}, 64'd24);
        chk("clr_halted", {63'd0, halted_a}, 64'd0);
        chk("clr_ovf_b", {63'd0, ovf_b}, 64'd0);
        rd_check(3'd6, 0, 0, "status_clr");
        rd_check(3'd0, 0, 0, "cyc_clr");

        // Saturation on B: 14 cycles of +1 instructions, then 2 cycles of +2.
        // The instruction counter goes from 14 by +2 to 15, and the cycle
        // counter goes past 15.
        enable_i = 1'b1; pce1_i = 32'h10000; pce2_i = 0;
        for (int c = 0; c < 14; c++) step();
        chk("no_ovf_yet_b", {63'd0, ovf_b}, 64'd0);
        pce2_i = 32'h10004;
        step();
        chk("ins_sat_ovf_b", {63'd0, ovf_b}, 64'd1);
        step();
        enable_i = 1'b0;
        chk("ovf_a_clean", {63'd0, ovf_a}, 64'd0);
        rd_check(3'd0, 16, 15, "cyc_sat");
        rd_check(3'd1, 18, 15, "ins_sat");
        rd_check(3'd6, 1, 4'b1001, "status_sat");
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("sat_clear_ovf_b", {63'd0, ovf_b}, 64'd0);
        rd_check(3'd1, 0, 0, "ins_after_clr");

        // A read coincident with reset is dropped.
        req = 1'b1; sel = 3'd6; reset = 1'b0;
        step();
        req = 1'b0; reset = 1'b1;
        chk("rst_read_drop", {63'd0, rd_a.rd_ack_o}, 64'd0);

        // Randomized traffic checked only by the model.
        for (int c = 0; c < 3000; c++) begin
            enable_i = ($urandom_range(0, 9) != 0);
            clear_i  = ($urandom_range(0, 24) == 0);
            reset    = ($urandom_range(0, 299) != 0);
            req      = 1'($urandom_range(0, 1));
            sel      = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 3))
                    0: pcf_i = 32'h10058;
                    1: pcf_i = HALT_PC;
                    2: pcf_i = PC_LIMIT;
                    default: pcf_i = $urandom;
                endcase
            end
            case ($urandom_range(0, 5))
                0: pce1_i = 0;
                1, 2: pce1_i = HALT_PC;
                3: pce1_i = 32'h10000;
                default: pce1_i = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: pce2_i = 0;
                1: pce2_i = PC_LIMIT;
                2: pce2_i = PC_LIMIT - 32'd1;
                3: pce2_i = 32'h10004;
                4: pce2_i = 32'hFFFF_FFFF;
                default: pce2_i = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: ope1_i = 7'h63;
                1: ope1_i = 7'h6f;
                2: ope1_i = 7'h67;
                3: ope1_i = 7'h33;
                default: ope1_i = 7'($urandom_range(0, 127));
            endcase
            mispredict_i = 1'($urandom_range(0, 1));
            taken_i      = 1'($urandom_range(0, 1));
            step();
            if (req && reset) $display("rand read sel=%0d a=%0h b=%0h", sel, rd_a.rd_data_o, rd_b.rd_data_o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ucsbece154b_perfmon.md
# ucsbece154b_perfmon

Synthesizable performance-monitor unit for the dual-issue pipeline. It sits beside the datapath and samples execute-stage events from both issue slots: PCs, the slot-1 opcode, mispredict and taken flags, plus the fetch PC. It accumulates cycle, instruction, branch and jump statistics and detects program completion. The counters are exported through a registered request/acknowledge read port, so software, a debug bridge or a bench can read the statistics without hierarchical probes.

## Interface
Parameters:
- WIDTH, 32, width of each event counter.
- HALT_PC, 32'h0001005c, execute-slot-1 PC that marks the final instruction.
- PC_LIMIT, 32'h00010060, slot-2 PCs at or above this value are not counted.

Ports:
- clk  in  1  core clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset; takes effect on the clk edge while low.
- enable_i  in  1  counting gate.
- pcf_i  in  32  fetch PC, slot 1.
- pce1_i  in  32  execute PC, slot 1.
- pce2_i  in  32  execute PC, slot 2.
- ope1_i  in  7  execute opcode, slot 1.
- mispredict_i  in  1  slot-1 branch mispredict in execute.
- taken_i  in  1  slot-1 branch/jump taken in execute.
- clear_i  in  1  synchronous clear of counters and state.
- rd_req_i  in  1  read request; single-cycle pulse.
- rd_sel_i  in  3  counter select.
- rd_ack_o  out  1  read data valid.
- rd_data_o  out  WIDTH  read data.
- halted_o  out  1  program-complete flag.
- overflow_o  out  1  sticky flag: some counter saturated.

## Operation
- State machine IDLE -> RUN -> HALTED.
  - IDLE -> RUN on the first cycle with enable_i=1. That cycle is counted.
  - RUN -> HALTED when pce1_i==HALT_PC and pcf_i equals the pcf_i registered on the previous cycle. The detecting cycle is counted.
  - HALTED is held until reset or clear_i. No counting takes place in IDLE or HALTED.
- In RUN, counters update only while enable_i=1.
- Counters (rd_sel encoding):
  - 0 cycles: +1 per counted cycle.
  - 1 instructions: +1 if pce1_i!=0, and a further +1 if pce2_i!=0 and pce2_i<PC_LIMIT (unsigned compare). Range is +0..+2 per cycle.
  - 2 branches: ope1_i==7'b1100011.
  - 3 branch misses: branch and mispredict_i=1.
  - 4 jumps: ope1_i is 7'b1101111 or 7'b1100111.
  - 5 jump misses: jump and taken_i=0.
- rd_sel 6 returns status: {zeros, overflow, halted, state[1:0]}, with state encoding IDLE=0, RUN=1, HALTED=2. rd_sel 7 returns 0.
- Saturation:
  - Each counter holds at all-ones and never wraps.
  - Any increment that would exceed all-ones sets overflow_o.
  - When the instruction counter is at all-ones minus 1 and the cycle carries +2, it saturates and sets overflow_o.
- clear_i zeroes all counters, overflow_o, halted_o and the previous-PC register, and returns the state to IDLE. The cycle in which clear_i is asserted is not counted. A low reset takes precedence over clear_i.
- halted_o=1 exactly while the state is HALTED.

## Timing
- Reset values: rd_ack_o=0, rd_data_o=0, halted_o=0, overflow_o=0, all counters 0, state IDLE, previous-PC register 0.
- Event-to-counter latency is 1 cycle: an event sampled at edge N is visible in the counter after edge N.
- Reads:
  - A request at edge N gives rd_ack_o=1 and rd_data_o for the cycle after edge N.
  - The data is the counter value before any update at edge N.
  - rd_ack_o is a single-cycle pulse. rd_data_o holds its last value between reads.
  - Back-to-back requests are accepted every cycle.
- A read coincident with clear_i returns the pre-clear value.
- A read coincident with a low reset is dropped: rd_ack_o=0.
- A reset or clear during RUN aborts counting immediately. The next counted cycle is the first enable_i=1 cycle after the state returns to IDLE.

## Test plan
- Reset low for 2 cycles, then read sel 0..6 -> every read is acked 1 cycle later with data 0. Status reads 0.
- Enable for 10 cycles with pce1=0x10000, pce2=0x10004, ope1=0x33 -> cycles=10, instructions=20, branches=0.
- Count pce2=0x10060 for 3 cycles with pce1 nonzero -> instructions +3 only. Count pce1=0 with pce2=0 -> instructions +0.
- Branch for 4 cycles with mispredict on 1 of them, plus jal for 2 cycles with taken 1 then 0 -> branches=4, br_miss=1, jumps=2, j_miss=1.
- Hold pcf=0x10060 for 2 cycles with pce1=0x1005c on the second -> halted_o rises after that edge, and cycles freeze while enable stays high.
- Preload the cycle count to 0xFFFFFFFE with WIDTH=32 via force, then run 3 cycles -> count=0xFFFFFFFF and overflow_o=1. clear_i then zeroes the count, overflow_o and halted_o, and returns the status state to 0.
